packet_scheduler: RTL and testbench
===================================

# packet_scheduler

Parametrised packet arbiter for the HDMI data-island path. It chooses the packet type for each data-island slot and supplies the audio-sample payload for that slot. It supersedes the fixed two-channel picker and adds:
- a single pixel-clock domain (callers synchronise audio before this block);
- configurable channel pairs with layout 0/1 selection;
- a deep sample FIFO with overflow flagging;
- configurable InfoFrame enable and repeat interval.

Header/subpacket generators downstream consume `packet_type` and the audio payload outputs.

## Interface
Parameters:
- AUDIO_BIT_WIDTH, 16: bits per audio sample, legal 16..24.
- CHANNEL_PAIRS, 1: stereo pairs per sample, legal 1..4. 1 selects layout 0; 2..4 selects layout 1.
- FIFO_DEPTH, 16: sample entries, power of two, ≥4.
- INFOFRAME_ENABLE, 3'b111: bit0 audio (0x84), bit1 AVI (0x82), bit2 SPD (0x83).
- INFOFRAME_FIELD_INTERVAL, 2: each enabled InfoFrame is sent once per this many video fields, legal 1..4.

Ports:
- clk_pixel  in  1  pixel clock; sole clock.
- reset  in  1  asynchronous, active-high.
- video_field_end  in  1  one-cycle pulse at end of video field.
- packet_enable  in  1  one-cycle pulse; a new packet slot starts, pulses ≥32 cycles apart.
- packet_pixel_counter  in  5  position within the current packet, 0..31.
- acr_request  in  1  one-cycle pulse; an Audio Clock Regeneration packet is due.
- audio_sample_valid  in  1  one-cycle strobe; audio_sample_word holds one full sample.
- audio_sample_word  in  2*CHANNEL_PAIRS*AUDIO_BIT_WIDTH  channels packed, channel 0 in the LSBs.
- audio_sample_ready  out  1  FIFO not full.
- packet_type  out  8  0x00 null, 0x01 ACR, 0x02 audio sample, 0x82/0x83/0x84 InfoFrames.
- audio_sample_word_packet  out  192  4 subpackets × 2 channels × 24 bits; subpacket 0 channel 0 in the LSBs.
- audio_sample_word_present_packet  out  4  subpacket-present bits.
- layout  out  1  0 when CHANNEL_PAIRS==1, else 1 (constant).
- frame_counter  out  8  IEC 60958 frame index of subpacket 0, 0..191.
- fifo_overflow  out  1  sticky: a sample was dropped.

## Operation
- FIFO entry = one complete sample, left-justified to 24 bits per channel, LSBs zero-padded.
- Push: on audio_sample_valid && !full. If valid && full, the sample is dropped and fifo_overflow is set; it clears only on reset.
- Occupancy uses pointers one bit wider than log2(FIFO_DEPTH).
- Push and pop in the same cycle are both honoured.
- Audio is eligible when:
  - layout 0: occupancy ≥4;
  - layout 1: occupancy ≥1.
- acr_pending is set by acr_request and cleared when ACR is selected. If a request arrives in the same cycle ACR is selected, pending stays set.
- Field counter: 0..INFOFRAME_FIELD_INTERVAL-1, advances on video_field_end. When it wraps to 0, all three sent flags clear.
- An InfoFrame is due when its enable bit is set and its sent flag is clear.
- Decision on packet_enable, priority high→low:
  1. acr_pending → 0x01.
  2. Audio eligible → 0x02 and pop.
  3. Due 0x84, then 0x82, then 0x83 → that type; set its sent flag.
  4. Otherwise → 0x00.
- video_field_end in the same cycle as packet_enable: the field end is processed and no decision is made; packet_type ← 0x00.
- Audio payload on pop:
  - Layout 0: the 4 oldest samples go to subpackets 0..3; present = 4'b1111; pop 4.
  - Layout 1: 1 sample is popped; pair i goes to subpacket i; present = low CHANNEL_PAIRS bits set; unused subpackets are zero.
- Frame counter: advances when packet_pixel_counter==31 && packet_type==0x02, by +4 (layout 0) or +1 (layout 1), modulo 192.
  - Wrap is computed in 9-bit arithmetic, e.g. 188+4 → 0.

## Timing
- Reset values:
  - packet_type 0x00;
  - payload 0, present 0, frame_counter 0;
  - fifo_overflow 0, audio_sample_ready 1;
  - acr_pending 0, sent flags 0, field counter 0, FIFO empty.
- packet_type and payload register one cycle after the packet_enable edge. They hold until the next decision or video_field_end.
- A sample pushed at edge N counts toward eligibility at decision edge N+1.
- audio_sample_ready is registered from post-update occupancy. It deasserts on the edge that fills the FIFO and reasserts on the edge that pops.
- Reset asserted mid-packet:
  - all state clears immediately (asynchronously);
  - after release, the first decision waits for the next packet_enable.

## Test plan
- Reset, then packet_enable ×4 with no audio or ACR, INTERVAL=2 → types 0x84, 0x82, 0x83, 0x00. After 2 video_field_end pulses, the next three decisions repeat the InfoFrame sequence.
- CHANNEL_PAIRS=1, AUDIO_BIT_WIDTH=16, push 0x1111..0x4444 (L), then packet_enable:
  - type 0x02, present 4'b1111;
  - subpacket 0 channel 0 = 24'h111100;
  - after pixel 31, frame_counter = 4.
- acr_request and ≥4 queued samples, then packet_enable ×2 → 0x01 then 0x02.
- CHANNEL_PAIRS=3, push 1 sample, packet_enable → layout 1, present 4'b0111, subpacket 3 = 0. Repeat 192 packets → frame_counter returns to 0.
- FIFO_DEPTH=4, push 5 samples with no pops → audio_sample_ready 0 after the 4th push; fifo_overflow 1 after the 5th and stays 1 through later pops.
- video_field_end coincident with packet_enable → packet_type 0x00, no pop, no sent flag changes except the interval clear.

Source files
------------

// File: rtl/packet_scheduler_if.sv
// Data-island scheduler bus: slot timing, ACR request and audio samples in; packet choice and audio payload out.
// master drives the slot/audio side, slave is the scheduler.
interface packet_scheduler_if #(
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int CHANNEL_PAIRS   = 1
);
  logic                                       video_field_end;
  logic                                       packet_enable;
  logic [4:0]                                 packet_pixel_counter;
  logic                                       acr_request;
  logic                                       audio_sample_valid;
  logic [2*CHANNEL_PAIRS*AUDIO_BIT_WIDTH-1:0] audio_sample_word;
  logic                                       audio_sample_ready;
  logic [7:0]                                 packet_type;
  logic [191:0]                               audio_sample_word_packet;
  logic [3:0]                                 audio_sample_word_present_packet;
  logic                                       layout;
  logic [7:0]                                 frame_counter;
  logic                                       fifo_overflow;

  modport master (
    output video_field_end, packet_enable, packet_pixel_counter, acr_request,
           audio_sample_valid, audio_sample_word,
    input  audio_sample_ready, packet_type, audio_sample_word_packet,
           audio_sample_word_present_packet, layout, frame_counter, fifo_overflow
  );

  modport slave (
    input  video_field_end, packet_enable, packet_pixel_counter, acr_request,
           audio_sample_valid, audio_sample_word,
    output audio_sample_ready, packet_type, audio_sample_word_packet,
           audio_sample_word_present_packet, layout, frame_counter, fifo_overflow
  );
endinterface

// File: rtl/packet_scheduler.sv
// HDMI data-island arbiter: picks the packet type one cycle after packet_enable and supplies audio payload.
// Samples queue in a FIFO; audio_sample_ready drops when full, and a sample offered while full is dropped and flagged.
module packet_scheduler #(
  parameter int         AUDIO_BIT_WIDTH          = 16,
  parameter int         CHANNEL_PAIRS            = 1,
  parameter int         FIFO_DEPTH               = 16,
  parameter logic [2:0] INFOFRAME_ENABLE         = 3'b111,
  parameter int         INFOFRAME_FIELD_INTERVAL = 2
) (
  input logic               clk_pixel,
  input logic               reset,
  packet_scheduler_if.slave bus
);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int EW     = 2 * CHANNEL_PAIRS * 24;
  localparam bit LAYOUT = (CHANNEL_PAIRS > 1);

  typedef logic [AW:0] ptr_t;
  localparam ptr_t POP_N = LAYOUT ? ptr_t'(1) : ptr_t'(4);

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  ptr_t          r_wr_ptr, r_rd_ptr;
  ptr_t          w_count, w_wr_nxt, w_rd_nxt, w_count_nxt;
  logic          r_ready, r_overflow, r_acr_pending;
  logic [2:0]    r_sent, w_sent_set, w_due;
  logic [1:0]    r_field;
  logic [7:0]    r_type, w_type, r_frame;
  logic [8:0]    w_frame_sum;
  logic [191:0]  r_payload, w_payload;
  logic [3:0]    r_present, w_present;
  logic          w_full, w_push, w_decide, w_eligible, w_pop, w_field_wrap;
  logic [EW-1:0] w_entry;

  assign w_count      = r_wr_ptr - r_rd_ptr;
  assign w_full       = (w_count == ptr_t'(FIFO_DEPTH));
  assign w_push       = bus.audio_sample_valid && !w_full;
  assign w_decide     = bus.packet_enable && !bus.video_field_end;
  assign w_eligible   = LAYOUT ? (w_count != '0) : (w_count >= ptr_t'(4));
  assign w_due        = INFOFRAME_ENABLE & ~r_sent;
  assign w_wr_nxt     = r_wr_ptr + ptr_t'(w_push);
  assign w_rd_nxt     = r_rd_ptr + (w_pop ? POP_N : '0);
  assign w_count_nxt  = w_wr_nxt - w_rd_nxt;
  assign w_field_wrap = bus.video_field_end &&
                        (r_field == 2'(INFOFRAME_FIELD_INTERVAL - 1));
  assign w_frame_sum  = {1'b0, r_frame} + (LAYOUT ? 9'd1 : 9'd4);

  // Left-justify every channel into a 24-bit lane.
  always_comb begin
    w_entry = '0;
    for (int c = 0; c < 2 * CHANNEL_PAIRS; c++) begin
      w_entry[c*24 +: 24] = 24'(bus.audio_sample_word[c*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH])
                            << (24 - AUDIO_BIT_WIDTH);
    end
  end

  always_comb begin
    w_type     = 8'h00;
    w_pop      = 1'b0;
    w_sent_set = 3'b000;
    if (w_decide) begin
      if (r_acr_pending) begin
        w_type = 8'h01;
      end else if (w_eligible) begin
        w_type = 8'h02;
        w_pop  = 1'b1;
      end else if (w_due[0]) begin
        w_type     = 8'h84;
        w_sent_set = 3'b001;
      end else if (w_due[1]) begin
        w_type     = 8'h82;
        w_sent_set = 3'b010;
      end else if (w_due[2]) begin
        w_type     = 8'h83;
        w_sent_set = 3'b100;
      end
    end
  end

  always_comb begin
    w_payload = '0;
    w_present = '0;
    if (!LAYOUT) begin
      for (int k = 0; k < 4; k++) begin
        w_payload[k*48 +: 48] = r_mem[AW'(r_rd_ptr[AW-1:0] + AW'(k))][47:0];
      end
      w_present = 4'b1111;
    end else begin
      w_payload[EW-1:0] = r_mem[r_rd_ptr[AW-1:0]];
      w_present         = 4'((1 << CHANNEL_PAIRS) - 1);
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_ready       <= 1'b1;
      r_overflow    <= 1'b0;
      r_acr_pending <= 1'b0;
      r_sent        <= '0;
      r_field       <= '0;
      r_type        <= 8'h00;
      r_payload     <= '0;
      r_present     <= '0;
      r_frame       <= '0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_ready  <= (w_count_nxt != ptr_t'(FIFO_DEPTH));
      if (bus.audio_sample_valid && w_full) r_overflow <= 1'b1;
      // A request landing on the ACR decision edge stays pending.
      r_acr_pending <= bus.acr_request || (r_acr_pending && !w_decide);
      r_sent <= w_field_wrap ? 3'b000 : (r_sent | w_sent_set);
      if (bus.video_field_end) begin
        r_field <= w_field_wrap ? 2'd0 : r_field + 2'd1;
        r_type  <= 8'h00;
      end
      if (w_decide) r_type <= w_type;
      if (w_pop) begin
        r_payload <= w_payload;
        r_present <= w_present;
      end
      if (bus.packet_pixel_counter == 5'd31 && r_type == 8'h02) begin
        r_frame <= (w_frame_sum >= 9'd192) ? 8'(w_frame_sum - 9'd192) : w_frame_sum[7:0];
      end
    end
  end

  assign bus.audio_sample_ready               = r_ready;
  assign bus.packet_type                      = r_type;
  assign bus.audio_sample_word_packet         = r_payload;
  assign bus.audio_sample_word_present_packet = r_present;
  assign bus.layout                           = LAYOUT;
  assign bus.frame_counter                    = r_frame;
  assign bus.fifo_overflow                    = r_overflow;
endmodule

// File: tb/tb_packet_scheduler.sv
// Directed bench: three scheduler instances (stereo/16-deep, three pairs, stereo/4-deep) on one pixel clock.
module tb_packet_scheduler;
  logic       clk_pixel = 1'b0;
  logic       reset     = 1'b1;
  int         n_cmp     = 0;
  int         n_err     = 0;
  logic [7:0] ty_a, ty_b, ty_c;
  logic [95:0] wb;

  always #5 clk_pixel = ~clk_pixel;

  packet_scheduler_if #(.AUDIO_BIT_WIDTH(16), .CHANNEL_PAIRS(1)) ifa ();
  packet_scheduler_if #(.AUDIO_BIT_WIDTH(16), .CHANNEL_PAIRS(3)) ifb ();
  packet_scheduler_if #(.AUDIO_BIT_WIDTH(16), .CHANNEL_PAIRS(1)) ifc ();

  packet_scheduler #(.AUDIO_BIT_WIDTH(16), .CHANNEL_PAIRS(1), .FIFO_DEPTH(16),
                     .INFOFRAME_ENABLE(3'b111), .INFOFRAME_FIELD_INTERVAL(2))
    u_a (.clk_pixel(clk_pixel), .reset(reset), .bus(ifa.slave));
  packet_scheduler #(.AUDIO_BIT_WIDTH(16), .CHANNEL_PAIRS(3), .FIFO_DEPTH(16),
                     .INFOFRAME_ENABLE(3'b111), .INFOFRAME_FIELD_INTERVAL(2))
    u_b (.clk_pixel(clk_pixel), .reset(reset), .bus(ifb.slave));
  packet_scheduler #(.AUDIO_BIT_WIDTH(16), .CHANNEL_PAIRS(1), .FIFO_DEPTH(4),
                     .INFOFRAME_ENABLE(3'b111), .INFOFRAME_FIELD_INTERVAL(2))
    u_c (.clk_pixel(clk_pixel), .reset(reset), .bus(ifc.slave));

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic set_pixel(input logic [4:0] p);
    ifa.packet_pixel_counter = p;
    ifb.packet_pixel_counter = p;
    ifc.packet_pixel_counter = p;
  endtask

  // One 32-cycle packet slot; m selects which instances see packet_enable.
  task automatic slot(input logic [2:0] m, input logic fe);
    ifa.packet_enable   = m[0];
    ifb.packet_enable   = m[1];
    ifc.packet_enable   = m[2];
    ifa.video_field_end = fe;
    set_pixel(5'd0);
    tick();
    ifa.packet_enable   = 1'b0;
    ifb.packet_enable   = 1'b0;
    ifc.packet_enable   = 1'b0;
    ifa.video_field_end = 1'b0;
    ty_a = ifa.packet_type;
    ty_b = ifb.packet_type;
    ty_c = ifc.packet_type;
    for (int p = 1; p < 32; p++) begin
      set_pixel(5'(p));
      tick();
    end
    set_pixel(5'd0);
  endtask

  task automatic push_a(input logic [31:0] w);
    ifa.audio_sample_valid = 1'b1;
    ifa.audio_sample_word  = w;
    tick();
    ifa.audio_sample_valid = 1'b0;
  endtask

  task automatic push_b(input logic [95:0] w);
    ifb.audio_sample_valid = 1'b1;
    ifb.audio_sample_word  = w;
    tick();
    ifb.audio_sample_valid = 1'b0;
  endtask

  task automatic push_c(input logic [31:0] w);
    ifc.audio_sample_valid = 1'b1;
    ifc.audio_sample_word  = w;
    tick();
    ifc.audio_sample_valid = 1'b0;
  endtask

  task automatic field_end_a();
    ifa.video_field_end = 1'b1;
    tick();
    ifa.video_field_end = 1'b0;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    ifa.video_field_end = 0; ifa.packet_enable = 0; ifa.packet_pixel_counter = 0;
    ifa.acr_request = 0; ifa.audio_sample_valid = 0; ifa.audio_sample_word = '0;
    ifb.video_field_end = 0; ifb.packet_enable = 0; ifb.packet_pixel_counter = 0;
    ifb.acr_request = 0; ifb.audio_sample_valid = 0; ifb.audio_sample_word = '0;
    ifc.video_field_end = 0; ifc.packet_enable = 0; ifc.packet_pixel_counter = 0;
    ifc.acr_request = 0; ifc.audio_sample_valid = 0; ifc.audio_sample_word = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_type",     ifa.packet_type, 8'h00);
    check("rst_payload",  ifa.audio_sample_word_packet, 192'h0);
    check("rst_present",  ifa.audio_sample_word_present_packet, 4'h0);
    check("rst_frame",    ifa.frame_counter, 8'd0);
    check("rst_overflow", ifa.fifo_overflow, 1'b0);
    check("rst_ready",    ifa.audio_sample_ready, 1'b1);
    check("layout_a",     ifa.layout, 1'b0);
    check("layout_b",     ifb.layout, 1'b1);

    // InfoFrame rotation, then re-armed after two field ends.
    slot(3'b001, 1'b0); check("if1_84", ty_a, 8'h84);
    slot(3'b001, 1'b0); check("if1_82", ty_a, 8'h82);
    slot(3'b001, 1'b0); check("if1_83", ty_a, 8'h83);
    slot(3'b001, 1'b0); check("if1_00", ty_a, 8'h00);
    field_end_a();
    field_end_a();
    slot(3'b001, 1'b0); check("if2_84", ty_a, 8'h84);
    slot(3'b001, 1'b0); check("if2_82", ty_a, 8'h82);
    slot(3'b001, 1'b0); check("if2_83", ty_a, 8'h83);

    // Layout 0 audio: four stereo samples per packet.
    push_a({16'hA001, 16'h1111});
    push_a({16'hA002, 16'h2222});
    push_a({16'hA003, 16'h3333});
    push_a({16'hA004, 16'h4444});
    slot(3'b001, 1'b0);
    check("aud_type",    ty_a, 8'h02);
    check("aud_present", ifa.audio_sample_word_present_packet, 4'b1111);
    check("aud_sp0_l",   ifa.audio_sample_word_packet[23:0], 24'h111100);
    check("aud_sp0_r",   ifa.audio_sample_word_packet[47:24], 24'hA00100);
    check("aud_sp3_l",   ifa.audio_sample_word_packet[167:144], 24'h444400);
    check("aud_sp3_r",   ifa.audio_sample_word_packet[191:168], 24'hA00400);
    check("aud_frame4",  ifa.frame_counter, 8'd4);

    // ACR outranks queued audio.
    ifa.acr_request = 1'b1;
    tick();
    ifa.acr_request = 1'b0;
    push_a({16'hA005, 16'h5555});
    push_a({16'hA006, 16'h6666});
    push_a({16'hA007, 16'h7777});
    push_a({16'hA008, 16'h8888});
    slot(3'b001, 1'b0); check("acr_first",  ty_a, 8'h01);
    slot(3'b001, 1'b0); check("acr_then_aud", ty_a, 8'h02);
    check("acr_sp0_l", ifa.audio_sample_word_packet[23:0], 24'h555500);
    check("frame8",    ifa.frame_counter, 8'd8);

    // Field end on a decision edge: no decision, no pop.
    push_a({16'hA009, 16'h9999});
    push_a({16'hA00A, 16'hAAAA});
    push_a({16'hA00B, 16'hBBBB});
    push_a({16'hA00C, 16'hCCCC});
    slot(3'b001, 1'b1); check("fe_coinc_type", ty_a, 8'h00);
    check("fe_coinc_frame", ifa.frame_counter, 8'd8);
    slot(3'b001, 1'b0); check("fe_no_pop", ty_a, 8'h02);
    check("fe_sp0_l", ifa.audio_sample_word_packet[23:0], 24'h999900);
    check("frame12",  ifa.frame_counter, 8'd12);
    slot(3'b001, 1'b0); check("fe_sent_kept", ty_a, 8'h00);
    field_end_a();
    slot(3'b001, 1'b0); check("fe_wrap_clear", ty_a, 8'h84);

    // Overflow on a 4-deep FIFO.
    push_c({16'hF001, 16'h0101});
    push_c({16'hF002, 16'h0202});
    push_c({16'hF003, 16'h0303});
    check("ovf_rdy3", ifc.audio_sample_ready, 1'b1);
    push_c({16'hF004, 16'h0404});
    check("ovf_rdy4", ifc.audio_sample_ready, 1'b0);
    check("ovf_flag4", ifc.fifo_overflow, 1'b0);
    push_c({16'hF005, 16'h0505});
    check("ovf_flag5", ifc.fifo_overflow, 1'b1);
    slot(3'b100, 1'b0);
    check("ovf_pop_type", ty_c, 8'h02);
    check("ovf_sp3_l",    ifc.audio_sample_word_packet[167:144], 24'h040400);
    check("ovf_rdy_pop",  ifc.audio_sample_ready, 1'b1);
    check("ovf_sticky1",  ifc.fifo_overflow, 1'b1);
    slot(3'b100, 1'b0);
    check("ovf_empty",    ty_c, 8'h84);
    check("ovf_sticky2",  ifc.fifo_overflow, 1'b1);

    // Layout 1, three pairs: one sample per packet, frame counter wraps at 192.
    for (int i = 0; i < 192; i++) begin
      wb = '0;
      for (int c = 0; c < 6; c++) wb[c*16 +: 16] = 16'h1000 + 16'(c) + 16'(i << 4);
      push_b(wb);
      slot(3'b010, 1'b0);
      check("l1_type", ty_b, 8'h02);
      if (i == 0) begin
        check("l1_present", ifb.audio_sample_word_present_packet, 4'b0111);
        check("l1_sp0_c0",  ifb.audio_sample_word_packet[23:0], 24'h100000);
        check("l1_sp0_c1",  ifb.audio_sample_word_packet[47:24], 24'h100100);
        check("l1_sp2_c1",  ifb.audio_sample_word_packet[143:120], 24'h100500);
        check("l1_sp3_zero", ifb.audio_sample_word_packet[191:144], 48'h0);
        check("l1_frame1",  ifb.frame_counter, 8'd1);
      end
      if (i == 190) check("l1_frame191", ifb.frame_counter, 8'd191);
    end
    check("l1_frame_wrap", ifb.frame_counter, 8'd0);

    // Asynchronous reset in the middle of a packet.
    ifa.packet_enable = 1'b1;
    tick();
    ifa.packet_enable = 1'b0;
    check("pre_rst_type", ifa.packet_type, 8'h82);
    for (int p = 1; p < 10; p++) begin
      set_pixel(5'(p));
      tick();
    end
    #2 reset = 1'b1;
    #1;
    check("arst_type",    ifa.packet_type, 8'h00);
    check("arst_payload", ifa.audio_sample_word_packet, 192'h0);
    check("arst_frame",   ifa.frame_counter, 8'd0);
    set_pixel(5'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    check("post_rst_idle", ifa.packet_type, 8'h00);
    slot(3'b001, 1'b0); check("post_rst_84", ty_a, 8'h84);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
